// File: rtl/prog_loader.sv
// Program loader and run supervisor: streams instructions into imem, pulses core start, then times the run until halt.
// Optional RUN-cycle watchdog enabled by defining LOADER_TIMEOUT_EN (limit set by TIMEOUT).
module prog_loader #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned INST_W     = 9,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned START_HOLD = 4,
    parameter int unsigned TIMEOUT    = 1000000
) (
    input  logic              CLK,
    input  logic              init,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              core_start,
    input  logic              core_halt,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int unsigned HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);
`ifdef LOADER_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_LOAD,
        S_START,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [HOLD_W-1:0] hold;
    logic              accept;
    logic              addr_full;
    logic              cnt_sat;
    logic              timeout_hit;

    // Write port is a zero-latency pass-through of the accepted word.
    assign in_ready    = (state == S_LOAD) & ~init;
    assign accept      = in_valid & in_ready;
    assign imem_we     = accept;
    assign imem_addr   = addr;
    assign imem_wdata  = in_data;
    assign addr_full   = &addr;
    assign cnt_sat     = &cycle_count;
    assign timeout_hit = TIMEOUT_EN && (cycle_count == TO_LAST);

    always_ff @(posedge CLK) begin
        if (init) begin
            state       <= S_LOAD;
            addr        <= '0;
            hold        <= '0;
            core_start  <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            cycle_count <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    core_start <= 1'b1;
                    if (accept) begin
                        // Address sticks at the top on overflow; no wrap onto word 0.
                        if (!addr_full) begin
                            addr <= addr + ADDR_W'(1);
                        end
                        if (in_last) begin
                            state <= S_START;
                            hold  <= '0;
                        end else if (addr_full) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                S_START: begin
                    hold <= hold + HOLD_W'(1);
                    if (hold == HOLD_LAST) begin
                        state      <= S_RUN;
                        core_start <= 1'b0;
                    end else begin
                        core_start <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (core_halt) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        if (!cnt_sat) begin
                            cycle_count <= cycle_count + CNT_W'(1);
                        end
                        // Watchdog trip parks the core back under start.
                        if (timeout_hit) begin
                            state      <= S_ERR;
                            err        <= 1'b1;
                            core_start <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    core_start <= 1'b0;
                    done       <= 1'b1;
                end
                S_ERR: begin
                    core_start <= 1'b1;
                    err        <= 1'b1;
                end
                default: begin
                    state      <= S_LOAD;
                    core_start <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected imem writes queued at stimulus, checked by a write monitor.
module tb_prog_loader;

    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned INST_W     = 9;
    localparam int unsigned CNT_W      = 32;
    localparam int unsigned START_HOLD = 4;
    localparam int unsigned TIMEOUT    = 20;

    logic              CLK = 1'b0;
    logic              init;
    logic              in_valid;
    logic [INST_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_wdata;
    logic              core_start;
    logic              core_halt;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  cycle_count;

    always #5 CLK = ~CLK;

    prog_loader #(
        .ADDR_W    (ADDR_W),
        .INST_W    (INST_W),
        .CNT_W     (CNT_W),
        .START_HOLD(START_HOLD),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .init       (init),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_start (core_start),
        .core_halt  (core_halt),
        .done       (done),
        .err        (err),
        .cycle_count(cycle_count)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [INST_W-1:0] data;
    } wr_t;

    wr_t               exp_q[$];
    wr_t               mon_e;
    int                vectors     = 0;
    int                miscompares = 0;
    logic [ADDR_W-1:0] exp_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every imem write must match the head of the expected-write queue.
    always @(negedge CLK) begin
        if (imem_we !== 1'b0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: we=%b addr=%0d data=0x%0h expected no write at %0t",
                         imem_we, imem_addr, imem_wdata, $time);
            end else begin
                mon_e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== mon_e) begin
                    miscompares++;
                    $display("FAIL imem_write: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h at %0t",
                             imem_addr, imem_wdata, mon_e.addr, mon_e.data, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [INST_W-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        exp_q.push_back({exp_addr, d});
        exp_addr++;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        init      = 1'b1;
        in_valid  = 1'b0;
        core_halt = 1'b0;
        step();
        init     = 1'b0;
        exp_addr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        init      = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        core_halt = 1'b0;
        exp_addr  = '0;

        // Reset state
        repeat (2) step();
        @(negedge CLK);
        chk("init_in_ready", in_ready, 1'b0);
        chk("init_we", imem_we, 1'b0);
        step();
        init = 1'b0;
        @(negedge CLK);
        chk("rst_core_start", core_start, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_count", cycle_count, 0);
        chk("rst_in_ready", in_ready, 1'b1);

        // Back-to-back load of three words, then START hold and RUN
        step();
        send(9'h1A0, 1'b0);
        send(9'h055, 1'b0);
        send(9'h1FF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("start_core_start", core_start, 1'b1);
            chk("start_in_ready", in_ready, 1'b0);
            step();
        end
        @(negedge CLK);
        chk("run_core_start", core_start, 1'b0);
        chk("run_count0", cycle_count, 0);
        repeat (10) step();
        core_halt = 1'b1;
        @(negedge CLK);
        chk("run_count10", cycle_count, 10);
        chk("run_done0", done, 1'b0);
        step();
        core_halt = 1'b0;
        @(negedge CLK);
        chk("done_done", done, 1'b1);
        chk("done_count", cycle_count, 10);
        chk("done_core_start", core_start, 1'b0);
        chk("done_in_ready", in_ready, 1'b0);
        in_valid = 1'b1;
        in_data  = 9'h0EE;
        for (int i = 0; i < 4; i++) begin
            core_halt = ~core_halt;
            step();
        end
        in_valid  = 1'b0;
        core_halt = 1'b0;
        @(negedge CLK);
        chk("done_sticky", done, 1'b1);
        chk("done_count_hold", cycle_count, 10);

        // Gapped load, then init during RUN
        do_reset();
        send(9'h011, 1'b0);
        step();
        send(9'h022, 1'b0);
        step();
        send(9'h033, 1'b1);
        repeat (4) step();
        repeat (5) step();
        @(negedge CLK);
        chk("gap_run_count5", cycle_count, 5);
        chk("gap_run_core_start", core_start, 1'b0);
        init = 1'b1;
        step();
        init     = 1'b0;
        exp_addr = '0;
        @(negedge CLK);
        chk("midrun_count", cycle_count, 0);
        chk("midrun_core_start", core_start, 1'b1);
        chk("midrun_done", done, 1'b0);
        chk("midrun_err", err, 1'b0);
        chk("midrun_in_ready", in_ready, 1'b1);

        // init at addr 5 collides with an offered word: no write, address returns to 0
        step();
        for (int i = 0; i < 5; i++) send(INST_W'(9'h100 + i), 1'b0);
        init     = 1'b1;
        in_valid = 1'b1;
        in_data  = 9'h0AA;
        @(negedge CLK);
        chk("midload_we", imem_we, 1'b0);
        chk("midload_in_ready", in_ready, 1'b0);
        step();
        init     = 1'b0;
        in_valid = 1'b0;
        exp_addr = '0;
        @(negedge CLK);
        chk("midload_core_start", core_start, 1'b1);
        chk("midload_count", cycle_count, 0);
        step();
        send(9'h0BB, 1'b1);

        // Overflow: eight words without last
        do_reset();
        for (int i = 0; i < 8; i++) send(INST_W'(9'h080 + i), 1'b0);
        @(negedge CLK);
        chk("ovf_err", err, 1'b1);
        chk("ovf_in_ready", in_ready, 1'b0);
        chk("ovf_core_start", core_start, 1'b1);
        chk("ovf_done", done, 1'b0);
        in_valid = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        @(negedge CLK);
        chk("ovf_err_sticky", err, 1'b1);

        // Last word on the final address is legal
        do_reset();
        for (int i = 0; i < 8; i++) send(INST_W'(i), (i == 7));
        @(negedge CLK);
        chk("full_err", err, 1'b0);
        chk("full_core_start", core_start, 1'b1);
        chk("full_in_ready", in_ready, 1'b0);
        repeat (4) step();
`ifdef LOADER_TIMEOUT_EN
        repeat (19) step();
        @(negedge CLK);
        chk("to_pre_err", err, 1'b0);
        chk("to_pre_count", cycle_count, 19);
        step();
        @(negedge CLK);
        chk("to_err", err, 1'b1);
        chk("to_count", cycle_count, 20);
        chk("to_core_start", core_start, 1'b1);
        chk("to_done", done, 1'b0);
        repeat (5) step();
        @(negedge CLK);
        chk("to_count_frozen", cycle_count, 20);
`else
        repeat (100) step();
        @(negedge CLK);
        chk("long_count", cycle_count, 100);
        chk("long_err", err, 1'b0);
        chk("long_done", done, 1'b0);
        chk("long_core_start", core_start, 1'b0);
        core_halt = 1'b1;
        step();
        core_halt = 1'b0;
        @(negedge CLK);
        chk("long_done_after_halt", done, 1'b1);
        chk("long_count_after_halt", cycle_count, 100);
`endif

        @(negedge CLK);
        chk("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
